// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round count, FSM encoding and GF(2^8) doubling.
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned KEY_W   = 1408;
  localparam int unsigned NR      = 10;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StFinal
  } aes_fsm_e;

  // Multiply by 2 in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: inverse affine transform followed by GF(2^8) inversion.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  logic [7:0] pre;

  // Undo the affine step, then invert; x^254 is the inverse and maps 0 to 0.
  always_comb begin
    logic [7:0] sq;
    logic [7:0] acc;
    pre = rotl(data_i, 1) ^ rotl(data_i, 3) ^ rotl(data_i, 6) ^ 8'h05;
    sq  = pre;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    data_o = acc;
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock, 10-cycle latency.
// Optional feature: define AES_INV_KEY_LATCH_EN to capture the expanded key at
// the accepting edge; otherwise the key bus is read live and must stay stable.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLOCK_W-1:0] state,
  input  logic [KEY_W-1:0]   key,
  output logic [BLOCK_W-1:0] result,
  output logic               finish,
  output logic               busy
);

  aes_fsm_e           fsm_q, fsm_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BLOCK_W-1:0] work_q, work_d;
  logic [BLOCK_W-1:0] result_q, result_d;
  logic               finish_q, finish_d;
  logic               busy_q, busy_d;

  logic [KEY_W-1:0]   key_src;
  logic [10:0]        rk_base;
  logic [BLOCK_W-1:0] round_key;
  logic [BLOCK_W-1:0] shifted;
  logic [BLOCK_W-1:0] subbed;
  logic [BLOCK_W-1:0] added;
  logic [BLOCK_W-1:0] mixed;

  // Byte i of a block sits at [127-8i -: 8]; byte i is row i%4, column i/4.
  function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c-r+4)%4))) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        logic [7:0] x2, x4, x8;
        a[r]  = s[8*(15-(r+4*c)) +: 8];
        x2    = xtime(a[r]);
        x4    = xtime(x2);
        x8    = xtime(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      o[8*(15-(0+4*c)) +: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[8*(15-(1+4*c)) +: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[8*(15-(2+4*c)) +: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[8*(15-(3+4*c)) +: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

`ifdef AES_INV_KEY_LATCH_EN
  logic [KEY_W-1:0] key_q;

  // Snapshot the whole key schedule when a block is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
    end else if (fsm_q == StIdle && start) begin
      key_q <= key;
    end
  end

  assign key_src = key_q;
`else
  assign key_src = key;
`endif

  assign rk_base   = {cnt_q, 7'd0};
  assign round_key = key_src[rk_base +: BLOCK_W];
  assign shifted   = inv_shift_rows(work_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .data_i(shifted[8*i +: 8]),
      .data_o(subbed[8*i +: 8])
    );
  end

  assign added = subbed ^ round_key;
  assign mixed = inv_mix_columns(added);

  // Next-state logic: accept in idle, iterate rounds NR-1..1, finish with round 0.
  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    result_d = result_q;
    finish_d = 1'b0;
    busy_d   = busy_q;
    case (fsm_q)
      StIdle: begin
        if (start) begin
          // Initial AddRoundKey uses the live bus even when latching: same edge.
          work_d = state ^ key[KEY_W-1 -: BLOCK_W];
          cnt_d  = 4'(NR - 1);
          busy_d = 1'b1;
          fsm_d  = StRound;
        end
      end
      StRound: begin
        work_d = mixed;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) fsm_d = StFinal;
      end
      StFinal: begin
        result_d = added;
        finish_d = 1'b1;
        busy_d   = 1'b0;
        fsm_d    = StIdle;
      end
      default: begin
        fsm_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= StIdle;
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      result_q <= result_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
    end
  end

  assign result = result_q;
  assign finish = finish_q;
  assign busy   = busy_q;

endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request one decryption; sampled only in IDLE.
REQ-004 SHALL have port state, input, 128 bits: ciphertext block; FIPS-197 byte 0 at [127:120], column-major.
REQ-005 SHALL have port key, input, 1408 bits: expanded key; round r key at [r*128+127 : r*128], r = 0..10.
REQ-006 SHALL have port result, output reg, 128 bits: plaintext block, same byte order as state.
REQ-007 SHALL have port finish, output reg, 1 bit: one-cycle pulse marking result valid.
REQ-008 SHALL have port busy, output reg, 1 bit: high while a decryption is in progress.

Function
REQ-009 SHALL implement a three-state FSM: IDLE, ROUND, FINAL.
REQ-010 IDLE with start=1 at edge N SHALL load the working register with state XOR key round 10, set the round counter to 9, set busy=1, and go to ROUND.
REQ-011 Each ROUND edge SHALL apply, in this order, InvShiftRows, InvSubBytes, AddRoundKey(round counter), InvMixColumns, then decrement the counter.
REQ-012 ROUND with counter=1 SHALL process round 1 and go to FINAL. Rounds 9..1 occupy edges N+1..N+9.
REQ-013 FINAL at edge N+10 SHALL apply InvShiftRows, InvSubBytes and AddRoundKey(0), write result, set finish=1 and busy=0, and return to IDLE.
REQ-014 Latency SHALL be fixed at 10 cycles from the start edge to the edge where finish rises; throughput SHALL be one block per 11 cycles.
REQ-015 finish SHALL be high for exactly one cycle.
REQ-016 result SHALL hold its value until the next FINAL write or reset.
REQ-017 start while busy=1 SHALL be ignored. It SHALL NOT restart, queue or corrupt the operation.
REQ-018 start high in the cycle finish is high (FSM in IDLE) SHALL be accepted, giving back-to-back operation.
REQ-019 The state input SHALL be sampled only at the accepting edge. Later changes SHALL have no effect.
REQ-020 All byte arithmetic SHALL be GF(2^8) with polynomial 0x11B. InvMixColumns SHALL use coefficients 0E, 0B, 0D, 09.

Reset
REQ-021 rst=1 SHALL force result=0, finish=0, busy=0, FSM=IDLE, round counter=0 and working register=0.
REQ-022 rst asserted mid-operation SHALL abort it with no finish pulse; start in the same cycle as rst SHALL be ignored.
REQ-023 After rst falls, the first start SHALL behave as in REQ-010.

Configuration
REQ-024 With macro AES_INV_KEY_LATCH_EN defined, key SHALL be captured into an internal 1408-bit register at the accepting edge, and all rounds SHALL use the captured copy.
REQ-025 Without AES_INV_KEY_LATCH_EN, key SHALL be read live each cycle and SHALL be held stable by the source from start until finish. Changing it mid-operation gives an undefined result.

Structure
REQ-026 Shared package aes_pkg SHALL hold BLOCK_W=128, KEY_W=1408, NR=10, the FSM state encoding and the GF multiply-by-2 helper.
REQ-027 Inverse S-box SHALL be one combinational sub-module aes_inv_sbox (8-bit in, 8-bit out), instantiated 16 times.

Verification
REQ-028 FIPS-197 C.1: key expanded from 000102030405060708090a0b0c0d0e0f, state 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> result 00112233445566778899aabbccddeeff, finish exactly 10 cycles after start.
REQ-029 FIPS-197 App. B: key expanded from 2b7e151628aed2a6abf7158809cf4f3c, state 3925841d02dc09fbdc118597196a0b32 -> result 3243f6a8885a308d313198a2e0370734.
REQ-030 Start held high for 30 cycles with C.1 inputs -> finish pulses at cycles 10 and 21, each one cycle wide, both results correct.
REQ-031 start re-pulsed at cycle 4 of an operation, with state changed to all zeros -> ignored; C.1 result still produced at cycle 10.
REQ-032 rst asserted at cycle 5 -> result=0, busy=0, no finish; next start yields the correct C.1 result.
REQ-033 key bus scrambled after the start edge -> with AES_INV_KEY_LATCH_EN the result is correct; without it the bench flags the protocol violation.
